// File: rtl/operand_stack_pkg.sv
// Shared constants for the operand stack: mode encodings and a depth-width helper.
package operand_stack_pkg;

    typedef enum logic [2:0] {
        STACK_MODE_IDLE  = 3'b000,
        STACK_MODE_PUSH  = 3'b001,
        STACK_MODE_POP   = 3'b010,
        STACK_MODE_SWAP  = 3'b011,
        STACK_MODE_RESET = 3'b100
    } stack_mode_e;

    // Depth counter must represent 0..depth inclusive.
    function automatic int depth_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/operand_stack.sv
// Shift-register operand stack with push/pop/swap/clear and sticky overflow/underflow flags.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_word,
    input  logic [2:0]                    mode,
    output logic [WIDTH-1:0]              top_word,
    output logic [WIDTH-1:0]              second_word,
    output logic [depth_width(DEPTH)-1:0] depth,
    output logic                          empty,
    output logic                          full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int DW = depth_width(DEPTH);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        entry_d     = entry_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        case (mode)
            STACK_MODE_PUSH: begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    entry_d[i] = entry_q[i-1];
                end
                entry_d[0] = in_word;
                if (depth_q == DEPTH_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    depth_d = depth_q + DEPTH_ONE;
                end
            end
            STACK_MODE_POP: begin
                if (depth_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        entry_d[i] = entry_q[i+1];
                    end
                    entry_d[DEPTH-1] = '0;
                    depth_d = depth_q - DEPTH_ONE;
                end
            end
            STACK_MODE_SWAP: begin
                if (depth_q < DEPTH_TWO) begin
                    underflow_d = 1'b1;
                end else begin
                    entry_d[0] = entry_q[1];
                    entry_d[1] = entry_q[0];
                end
            end
            STACK_MODE_RESET: begin
                entry_d     = '{default: '0};
                depth_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: the storage array is reset too, because invalid entries must read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q     <= '{default: '0};
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign top_word    = entry_q[0];
    assign second_word = entry_q[1];
    assign depth       = depth_q;
    assign empty       = (depth_q == '0);
    assign full        = (depth_q == DEPTH_MAX);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
